// File: rtl/pipe_skid_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_stage_pkg: shared state encoding and bubble constants      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [31:0] C_BUBBLE_NOP_RV32 = 32'h0000_0013;
  localparam logic [63:0] C_BUBBLE_ZERO64   = 64'h0;

  function automatic logic [1:0] occupancy_of(input state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_stage_sat_counter: saturating event counter, no wrap       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_skid_stage_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_stage: valid/ready stage with 2-entry skid and flush       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int          DW     = 64,
  parameter logic [DW-1:0] BUBBLE = {DW{1'b0}},
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; stale main/skid contents are masked by state.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = occupancy_of(state_q);

  pipe_skid_stage_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (out_valid & ~out_ready),
    .value_o (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_skid_stage: vector table, corner sequences, scoreboard       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_skid_stage;

  localparam int          DW  = 64;
  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;
  logic          in_ready3, out_valid3;
  logic [DW-1:0] out_data3;
  logic [1:0]    occupancy3;
  logic [2:0]    stall_cnt3;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DW(DW), .BUBBLE(BUB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DW(DW), .BUBBLE(BUB), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occupancy3), .stall_cnt(stall_cnt3)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  int unsigned exp_stall, exp_stall3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: decide this cycle's fires from the model, check against the DUT.
  always @(negedge clk) begin
    int occ_before;
    if (reset) begin
      sb_q.delete();
      exp_stall  = 0;
      exp_stall3 = 0;
    end else begin
      occ_before = sb_q.size();
      check("occupancy", 64'(occupancy), 64'(occ_before));
      check("out_valid", 64'(out_valid), 64'(occ_before != 0));
      check("in_ready", 64'(in_ready), 64'(occ_before != 2));
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      check("stall_cnt3", 64'(stall_cnt3), 64'(exp_stall3));
      check("dut3_occupancy", 64'(occupancy3), 64'(occ_before));
      if (occ_before == 0) begin
        check("bubble", out_data, BUB);
      end else begin
        check("out_data_order", out_data, sb_q[0]);
      end
      if (occ_before != 0 && out_ready) begin
        void'(sb_q.pop_front());
      end
      if (occ_before != 0 && !out_ready) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall3 < 7) exp_stall3++;
      end
      if (in_valid && (occ_before != 2) && !flush) begin
        sb_q.push_back(in_data);
      end
      if (flush) begin
        sb_q.delete();
      end
    end
  end

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [63:0] od;
    logic        ir;
    logic [1:0]  occ;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b1, 64'd5,  1'b0, 1'b0, 1'b1, 64'd5,  1'b1, 2'd1};
    vt[1]  = '{1'b1, 64'd6,  1'b0, 1'b0, 1'b1, 64'd5,  1'b0, 2'd2};
    vt[2]  = '{1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 64'd5,  1'b0, 2'd2};
    vt[3]  = '{1'b0, 64'd0,  1'b1, 1'b0, 1'b1, 64'd6,  1'b1, 2'd1};
    vt[4]  = '{1'b0, 64'd0,  1'b1, 1'b0, 1'b0, BUB,    1'b1, 2'd0};
    vt[5]  = '{1'b1, 64'd7,  1'b1, 1'b0, 1'b1, 64'd7,  1'b1, 2'd1};
    vt[6]  = '{1'b1, 64'd8,  1'b1, 1'b0, 1'b1, 64'd8,  1'b1, 2'd1};
    vt[7]  = '{1'b1, 64'd9,  1'b0, 1'b0, 1'b1, 64'd8,  1'b0, 2'd2};
    vt[8]  = '{1'b1, 64'd10, 1'b0, 1'b1, 1'b0, BUB,    1'b1, 2'd0};
    vt[9]  = '{1'b0, 64'd0,  1'b1, 1'b0, 1'b0, BUB,    1'b1, 2'd0};
    vt[10] = '{1'b1, 64'd11, 1'b0, 1'b0, 1'b1, 64'd11, 1'b1, 2'd1};
    vt[11] = '{1'b1, 64'd12, 1'b1, 1'b1, 1'b0, BUB,    1'b1, 2'd0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hA; out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, BUB);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    reset = 1'b0;
    step();
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_data", out_data, 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("drain_out_valid", 64'(out_valid), 64'd0);

    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 64'(k);
      step();
      check("stream_data", out_data, 64'(k));
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    for (int i = 0; i < 12; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy; flush = vt[i].fl;
      step();
      check("vec_out_valid", 64'(out_valid), 64'(vt[i].ov));
      check("vec_out_data", out_data, vt[i].od);
      check("vec_in_ready", 64'(in_ready), 64'(vt[i].ir));
      check("vec_occupancy", 64'(occupancy), 64'(vt[i].occ));
    end
    flush = 1'b0;

    // Asynchronous reset while holding a beat, then exact stall counting.
    in_valid = 1'b1; in_data = 64'd20; out_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_out_data", out_data, BUB);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_occupancy", 64'(occupancy), 64'd0);
    check("async_stall_cnt", 64'(stall_cnt), 64'd0);
    step();
    reset = 1'b0; in_data = 64'd21;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("stall_10", 64'(stall_cnt), 64'd10);
    repeat (2) step();
    check("stall_12", 64'(stall_cnt), 64'd12);
    check("stall_sat3", 64'(stall_cnt3), 64'd7);
    out_ready = 1'b1;
    step();
    check("stall_drain_data", out_data, BUB);

    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = {32'hC0DE_0000, 32'(i)};
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("final_queue_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, bubble injection and a saturating back-pressure counter. Successor to the fixed 32-bit fetch/decode latch: it carries a `DW`-bit payload (e.g. {pc, instr}) between any two pipeline stages. Back-pressure propagates through a registered `in_ready`, so no combinational ready path crosses the stage. Full throughput is one beat per cycle, in order, with no loss.

## Interface
- `DW`, 64: payload width in bits (e.g. pc + instruction).
- `BUBBLE`, `{DW{1'b0}}`: value driven on `out_data` while `out_valid`=0 (e.g. NOP encoding in the low bits).
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous; drops all held entries.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: registered; stage can accept a beat this cycle.
- `in_data` in DW: upstream payload.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DW: head payload, or `BUBBLE` when not valid.
- `occupancy` out 2: entries held (0..2).
- `stall_cnt` out CNT_W: cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- Input fire is `in_valid & in_ready`. Output fire is `out_valid & out_ready`.
- Storage: `main` register (head) plus `skid` register. State encodes EMPTY (0), ONE (main valid), FULL (main + skid valid). `occupancy` = 0/1/2 from state.
- EMPTY:
  - in fire -> ONE; main <= in_data.
- ONE:
  - in fire and out fire -> ONE; main <= in_data.
  - in fire only -> FULL; skid <= in_data; in_ready <= 0.
  - out fire only -> EMPTY.
  - neither -> hold.
- FULL (`in_ready`=0, so no input fire):
  - out fire -> ONE; main <= skid; in_ready <= 1.
  - otherwise hold.
- `in_ready` is a flop; it equals (next state != FULL).
- `out_valid` = (state != EMPTY). `out_data` = main when valid, else `BUBBLE`.
- Flush has highest priority:
  - Next state EMPTY; `in_ready` <= 1.
  - A beat presented or accepted in the flush cycle is discarded.
  - An output fire in the flush cycle still counts as delivered downstream.
- `stall_cnt` increments when `out_valid & ~out_ready`.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Payload is opaque. No arithmetic on data. Ordering is strictly FIFO.

## Timing
- Reset values: `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `occupancy`=0, `stall_cnt`=0, state EMPTY. main/skid are cleared to `BUBBLE`.
- Reset mid-operation: held entries are lost immediately (asynchronous). Outputs take reset values without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1).
- `in_ready` deasserts one cycle after the skid fills. It reasserts the cycle after the skid drains into main, or after flush.
- Sustained `in_valid`=`out_ready`=1: one beat per cycle, occupancy steady at 1.
- `out_ready` may toggle freely. `in_valid` must not depend combinationally on `in_ready`.

## Structure
- Shared pipeline package holds:
  - the state enum (EMPTY/ONE/FULL), and
  - the canonical `BUBBLE` constants (e.g. RV32 NOP 32'h0000_0013 for instruction payloads).
- No sub-module needed. Optionally factor the counter as `sat_counter` (CNT_W, inc, value) for reuse by other stall/perf counters.

## Test plan
- Reset with `in_valid`=1, `in_data`=64'hA: `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1. After release, A appears one cycle later.
- Stream 1..8 with `out_ready`=1 every cycle: outputs 1..8 on consecutive cycles, occupancy stays 1, `stall_cnt`=0.
- Send 5,6 with `out_ready`=0:
  - occupancy reaches 2 and `in_ready`=0 the next cycle.
  - Holding `out_ready`=0 for 10 cycles gives `stall_cnt`=10 (or 11 counting the first valid cycle; check exactly).
  - Then `out_ready`=1 yields 5 then 6, and `in_ready`=1 again.
- Flush while FULL (entries 7,8) with `in_valid`=1 carrying 9: next cycle occupancy=0, `out_data`=`BUBBLE`, `in_ready`=1. Neither 7, 8 nor 9 is ever output.
- CNT_W=3, stall 12 cycles: `stall_cnt` sticks at 7.
- Random `in_valid`/`out_ready` for 10k cycles against a scoreboard: no loss, no duplication, in-order delivery, `in_ready`=0 only when occupancy=2.
